// File: rtl/restoring_divider8b_pkg.sv
// Purpose : shared types and constants for the restoring divider slice.
// Latency : n/a (declarations only).
// Backpr. : n/a.
// Contents: default operand width, FSM state encoding, iteration-counter width helper.
package restoring_divider8b_pkg;

  localparam int DEF_WIDTH = 8;

  // Counter must hold 0..WIDTH.
  localparam int DEF_CNT_W = $clog2(DEF_WIDTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/restoring_divider8b_step.sv
// Purpose : one restoring-division iteration (shift, trial subtract, select).
// Latency : combinational, zero cycles.
// Backpr. : none; pure function of its inputs.
// Ports   : i_rem   - partial remainder entering the step (always < divisor)
//           i_dq    - dividend/quotient shift register entering the step
//           i_divisor - divisor
//           o_rem, o_dq - partial remainder and shift register after the step
module restoring_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_dq,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_dq
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_borrow;
  logic           w_unused_diff_msb;

  // {rem, dq} << 1: the dividend MSB moves into the partial remainder.
  assign w_shift = {i_rem, i_dq[WIDTH-1]};

  // WIDTH+1-bit trial subtraction; the extra borrow bit is the sign.
  assign {w_borrow, w_diff} = {1'b0, w_shift} - {2'b00, i_divisor};

  // A kept difference is always below the divisor, so its MSB is 0.
  assign w_unused_diff_msb = w_diff[WIDTH];

  assign o_rem = w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign o_dq  = {i_dq[WIDTH-2:0], ~w_borrow};

endmodule

// File: rtl/restoring_divider8b.sv
// Purpose : unsigned restoring divider, one quotient bit per clock.
// Latency : start accepted at edge 0, done pulses after edge WIDTH (WIDTH+1 cycles).
// Backpr. : start is ignored while busy; a start during done chains back-to-back.
// Ports   : clk, rst_n (async active-low), start, dividend, divisor  -> inputs
//           busy, done, quotient, remainder, div_by_zero            -> outputs
module restoring_divider8b
  import restoring_divider8b_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = cnt_width(WIDTH);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dq;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] w_rem_nx;
  logic [WIDTH-1:0] w_dq_nx;
  logic             w_accept;
  logic             w_last;

  restoring_div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_dq      (r_dq),
    .i_divisor (r_dvs),
    .o_rem     (w_rem_nx),
    .o_dq      (w_dq_nx)
  );

  assign w_accept = start && (r_state != ST_RUN);
  assign w_last   = (r_state == ST_RUN) && (r_cnt == CW'(WIDTH - 1));

  assign busy = (r_state == ST_RUN);
  assign done = (r_state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = ST_RUN;
      ST_RUN:  if (w_last) w_next = ST_DONE;
      ST_DONE: w_next = start ? ST_RUN : ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= '0;
      r_rem       <= '0;
      r_dq        <= '0;
      r_dvs       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt <= '0;
      r_rem <= '0;
      r_dq  <= dividend;
      r_dvs <= divisor;
    end else if (r_state == ST_RUN) begin
      r_cnt <= r_cnt + CW'(1);
      r_rem <= w_rem_nx;
      r_dq  <= w_dq_nx;
      // Results are published only on the step that enters DONE.
      if (w_last) begin
        quotient    <= w_dq_nx;
        remainder   <= w_rem_nx;
        div_by_zero <= (r_dvs == '0);
      end
    end
  end

endmodule

// File: tb/tb_restoring_divider8b.sv
module tb_restoring_divider8b;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  restoring_divider8b #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           cyc;
    string        tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  // Reference: plain integer division, with the RISC-V divide-by-zero convention.
  function automatic exp_t model(input int a, input int b, input int done_cyc, input string tag);
    exp_t e;
    if (b == 0) begin
      e.q  = (1 << W) - 1;
      e.r  = a[W-1:0];
      e.dz = 1'b1;
    end else begin
      e.q  = W'(a / b);
      e.r  = W'(a % b);
      e.dz = 1'b0;
    end
    e.cyc = done_cyc;
    e.tag = tag;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_q"},   quotient,    mon_e.q);
        check({mon_e.tag, "_r"},   remainder,   mon_e.r);
        check({mon_e.tag, "_dz"},  div_by_zero, mon_e.dz);
        check({mon_e.tag, "_cyc"}, cyc,         mon_e.cyc);
      end
    end
  end

  // Called at a negedge: start is high for the cycle in progress (cycle 0),
  // so done is expected in cycle WIDTH+1 counted from it.
  task automatic issue(input int a, input int b, input string tag);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    sb.push_back(model(a, b, cyc + W + 1, tag));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("done_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int a, b, mode;

    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_q",    quotient, 0);
    check("rst_r",    remainder, 0);
    check("rst_dz",   div_by_zero, 0);

    // Release and start together: the very first edge must accept.
    rst_n = 1'b1;
    issue(100, 7, "d100_7");
    wait_idle();

    issue(255, 1, "d255_1");
    wait_idle();
    issue(3, 200, "d3_200");
    wait_idle();

    issue(5, 0, "d5_0");
    wait_idle();

    // Second start mid-RUN must be ignored.
    issue(100, 7, "midrun");
    repeat (3) @(negedge clk);
    start    = 1'b1;
    dividend = 8'd9;
    divisor  = 8'd3;
    @(negedge clk);
    start = 1'b0;
    check("midrun_busy", busy, 1);
    wait_idle();

    // Start held through DONE: second division chains, busy dips for one cycle.
    start    = 1'b1;
    dividend = 8'd200;
    divisor  = 8'd10;
    sb.push_back(model(200, 10, cyc + W + 1, "held1"));
    for (int k = 1; k <= W + 2; k++) begin
      @(negedge clk);
      check("held_busy", busy, (k == W + 1) ? 0 : 1);
      if (k == W + 1) begin
        dividend = 8'd9;
        divisor  = 8'd4;
        sb.push_back(model(9, 4, cyc + W + 1, "held2"));
      end
    end
    start = 1'b0;
    wait_idle();

    // Reset in cycle 4 of a division: outputs clear at once, no done follows.
    start    = 1'b1;
    dividend = 8'd100;
    divisor  = 8'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    check("arst_q",    quotient, 0);
    check("arst_r",    remainder, 0);
    check("arst_dz",   div_by_zero, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    issue(77, 9, "post_rst");
    wait_idle();

    // Random operands against the reference model.
    repeat (300) begin
      a    = $urandom_range(0, 255);
      mode = $urandom_range(0, 9);
      if (mode == 0)      b = 0;
      else if (mode <= 3) b = $urandom_range(1, 15);
      else                b = $urandom_range(1, 255);
      issue(a, b, "rand");
      wait_idle();
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
